// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file command sequencer:
// command opcodes, FSM state encoding and an address range helper.
package rf_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR = 8'hAA;  // frame: opcode, address, data
  localparam logic [7:0] CMD_RF_RD = 8'hBB;  // frame: opcode, address

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_EXEC,
    ST_RD_ADDR,
    ST_RD_EXEC,
    ST_RD_WAIT,
    ST_TX_SEND
  } state_e;

  // True when the address byte has no bits set above the register-file
  // address range.
  function automatic logic addr_fits(input logic [7:0] b, input int unsigned aw);
    return (b >> aw) == 8'h00;
  endfunction

endpackage

// File: rtl/rf_cmd_ctrl.sv
// rf_cmd_ctrl: parses a UART byte stream into register-file write/read
// commands, drives the register-file access port with single-cycle strobes
// and returns read data to the UART transmitter over a valid/busy handshake.
//
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   rx_p_data/vld   received byte and its single-cycle valid pulse
//   RdData/_Valid   register-file read data and valid
//   tx_busy         transmitter cannot accept a byte
//   WrEn/RdEn       register-file write/read strobes (one cycle each)
//   Address/WrData  register-file address and write data
//   tx_p_data/vld   byte to transmit and its valid (held until accepted)
//   ctrl_busy       high whenever the sequencer is not idle
//   cmd_err         single-cycle pulse per protocol error
module rf_cmd_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RD_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            rx_p_data,
  input  logic                  rx_d_vld,
  input  logic [BUS_WIDTH-1:0]  RdData,
  input  logic                  RdData_Valid,
  input  logic                  tx_busy,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [BUS_WIDTH-1:0]  WrData,
  output logic [7:0]            tx_p_data,
  output logic                  tx_d_vld,
  output logic                  ctrl_busy,
  output logic                  cmd_err
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  // Next-state and next-output computation; every output is then registered
  // so the strobes appear exactly one cycle after the triggering byte.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_d_vld) begin
          if (rx_p_data == CMD_RF_WR)      state_d = ST_WR_ADDR;
          else if (rx_p_data == CMD_RF_RD) state_d = ST_RD_ADDR;
          else                             err_d   = 1'b1;
        end
      end

      ST_WR_ADDR, ST_RD_ADDR: begin
        if (rx_d_vld) begin
          if (!addr_fits(rx_p_data, ADDR_WIDTH)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_d = rx_p_data[ADDR_WIDTH-1:0];
            if (state_q == ST_WR_ADDR) begin
              state_d = ST_WR_DATA;
            end else begin
              state_d = ST_RD_EXEC;
              rd_en_d = 1'b1;
            end
          end
        end
      end

      ST_WR_DATA: begin
        if (rx_d_vld) begin
          wr_data_d = BUS_WIDTH'(rx_p_data);
          wr_en_d   = 1'b1;
          state_d   = ST_WR_EXEC;
        end
      end

      ST_WR_EXEC: begin
        err_d   = rx_d_vld;  // overrun: byte dropped
        state_d = ST_IDLE;
      end

      ST_RD_EXEC: begin
        err_d   = rx_d_vld;
        cnt_d   = '0;
        state_d = ST_RD_WAIT;
      end

      // The counter holds 0..RD_TIMEOUT-1 while waiting, so the abort error
      // appears RD_TIMEOUT cycles after RD_WAIT is entered.
      ST_RD_WAIT: begin
        err_d = rx_d_vld;
        if (RdData_Valid) begin
          tx_data_d = 8'(RdData);
          tx_vld_d  = 1'b1;
          state_d   = ST_TX_SEND;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_TX_SEND: begin
        err_d = rx_d_vld;
        if (tx_busy) begin
          tx_vld_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign tx_p_data = tx_data_q;
  assign tx_d_vld  = tx_vld_q;
  assign ctrl_busy = busy_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Directed bench for rf_cmd_ctrl with a small register-file model whose read
// latency can be stretched or suppressed.
module tb_rf_cmd_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] rx_p_data;
  logic       rx_d_vld;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       tx_busy;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] tx_p_data;
  logic       tx_d_vld;
  logic       ctrl_busy;
  logic       cmd_err;

  int vectors;
  int miscompares;

  // register-file model controls and pulse counters
  logic [7:0] mem [16];
  logic       rf_mute;
  int         rf_lat;
  int         pend;
  logic [3:0] paddr;
  int         wr_cnt, rd_cnt, err_cnt, both_cnt;

  rf_cmd_ctrl #(
    .BUS_WIDTH (8),
    .ADDR_WIDTH(4),
    .RD_TIMEOUT(4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .rx_p_data   (rx_p_data),
    .rx_d_vld    (rx_d_vld),
    .RdData      (RdData),
    .RdData_Valid(RdData_Valid),
    .tx_busy     (tx_busy),
    .WrEn        (WrEn),
    .RdEn        (RdEn),
    .Address     (Address),
    .WrData      (WrData),
    .tx_p_data   (tx_p_data),
    .tx_d_vld    (tx_d_vld),
    .ctrl_busy   (ctrl_busy),
    .cmd_err     (cmd_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Register-file model: rf_lat extra cycles of read latency (0 = next cycle).
  always @(posedge CLK) begin
    RdData_Valid <= 1'b0;
    if (WrEn) mem[Address] <= WrData;
    if (RdEn && !rf_mute) begin
      if (rf_lat == 0) begin
        RdData_Valid <= 1'b1;
        RdData       <= mem[Address];
      end else begin
        pend  <= rf_lat;
        paddr <= Address;
      end
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        RdData_Valid <= 1'b1;
        RdData       <= mem[paddr];
      end
    end
  end

  always @(negedge CLK) begin
    if (WrEn)         wr_cnt   = wr_cnt + 1;
    if (RdEn)         rd_cnt   = rd_cnt + 1;
    if (cmd_err)      err_cnt  = err_cnt + 1;
    if (WrEn && RdEn) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // one-cycle byte pulse; returns in the cycle after the byte
  task automatic drive(input logic [7:0] b);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    step();
    rx_d_vld  = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    wr_cnt = 0; rd_cnt = 0; err_cnt = 0; both_cnt = 0;
    pend = 0; paddr = '0; rf_mute = 1'b0; rf_lat = 0;
    RdData = '0; RdData_Valid = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    RST = 1'b0; rx_p_data = '0; rx_d_vld = 1'b0; tx_busy = 1'b0;
    step(); step(); step();

    // reset state
    chk("rst_wren",  32'(WrEn),      0);
    chk("rst_rden",  32'(RdEn),      0);
    chk("rst_txvld", 32'(tx_d_vld),  0);
    chk("rst_busy",  32'(ctrl_busy), 0);
    chk("rst_err",   32'(cmd_err),   0);
    chk("rst_addr",  32'(Address),   0);
    chk("rst_wdata", 32'(WrData),    0);
    chk("rst_txdat", 32'(tx_p_data), 0);
    RST = 1'b1;
    step();

    // write 0x5C to reg 3, then read it back
    drive(8'hAA); step();
    drive(8'h03); step();
    drive(8'h5C);
    chk("wr_wren",  32'(WrEn),      1);
    chk("wr_addr",  32'(Address),   3);
    chk("wr_data",  32'(WrData),    32'h5C);
    chk("wr_busy",  32'(ctrl_busy), 1);
    step();
    chk("wr_wren_off", 32'(WrEn),      0);
    chk("wr_idle",     32'(ctrl_busy), 0);
    chk("wr_hold_dat", 32'(WrData),    32'h5C);
    drive(8'hBB); step();
    drive(8'h03);                               // cycle N+1
    chk("rd_rden", 32'(RdEn),    1);
    chk("rd_addr", 32'(Address), 3);
    step();                                     // N+2
    chk("rd_rden_off", 32'(RdEn),     0);
    chk("rd_txvld_n2", 32'(tx_d_vld), 0);
    step();                                     // N+3
    chk("rd_txvld", 32'(tx_d_vld),  1);
    chk("rd_txdat", 32'(tx_p_data), 32'h5C);
    step();
    chk("rd_txvld_off", 32'(tx_d_vld),  0);
    chk("rd_idle",      32'(ctrl_busy), 0);
    step();
    chk("t1_wr_pulses", 32'(wr_cnt),  1);
    chk("t1_rd_pulses", 32'(rd_cnt),  1);
    chk("t1_no_err",    32'(err_cnt), 0);

    // TX back-pressure: tx_busy high for 10 cycles of TX_SEND
    tx_busy = 1'b1;
    drive(8'hBB); step();
    drive(8'h03); step(); step();               // N+3
    for (int i = 0; i < 10; i++) begin
      chk("bp_txvld", 32'(tx_d_vld),  1);
      chk("bp_txdat", 32'(tx_p_data), 32'h5C);
      chk("bp_busy",  32'(ctrl_busy), 1);
      step();
    end
    chk("bp_txvld_last", 32'(tx_d_vld), 1);
    tx_busy = 1'b0;
    step();
    chk("bp_released", 32'(tx_d_vld),  0);
    chk("bp_idle",     32'(ctrl_busy), 0);
    step();

    // illegal opcode, then out-of-range address
    drive(8'h5A);
    chk("ill_op_err",  32'(cmd_err),   1);
    chk("ill_op_idle", 32'(ctrl_busy), 0);
    step();
    chk("ill_op_err_off", 32'(cmd_err), 0);
    drive(8'hAA);
    chk("ill_wraddr_busy", 32'(ctrl_busy), 1);
    step();
    drive(8'hF2);
    chk("ill_addr_err",  32'(cmd_err),   1);
    chk("ill_addr_idle", 32'(ctrl_busy), 0);
    step();
    chk("ill_addr_err_off", 32'(cmd_err), 0);
    step();
    chk("ill_wr_pulses", 32'(wr_cnt),  1);
    chk("ill_rd_pulses", 32'(rd_cnt),  2);
    chk("ill_err_count", 32'(err_cnt), 2);

    // read timeout: register file never answers
    rf_mute = 1'b1;
    drive(8'hBB); step();
    drive(8'h01);                               // N+1
    chk("to_rden", 32'(RdEn), 1);
    for (int i = 0; i < 4; i++) begin           // N+2..N+5 in RD_WAIT
      step();
      chk("to_wait_err",  32'(cmd_err),   0);
      chk("to_wait_busy", 32'(ctrl_busy), 1);
    end
    step();                                     // N+6
    chk("to_err",   32'(cmd_err),   1);
    chk("to_idle",  32'(ctrl_busy), 0);
    chk("to_notx",  32'(tx_d_vld),  0);
    step();
    chk("to_err_off", 32'(cmd_err), 0);
    rf_mute = 1'b0;
    step();

    // reset mid-frame
    drive(8'hAA); step();
    drive(8'h02);
    chk("mr_busy", 32'(ctrl_busy), 1);
    chk("mr_addr", 32'(Address),   2);
    RST = 1'b0;
    #1;
    chk("mr_async_busy", 32'(ctrl_busy), 0);
    chk("mr_async_addr", 32'(Address),   0);
    chk("mr_async_wdat", 32'(WrData),    0);
    chk("mr_async_txd",  32'(tx_p_data), 0);
    step(); step();
    RST = 1'b1;
    step();
    drive(8'h77);
    chk("mr_77_err",  32'(cmd_err),   1);
    chk("mr_77_idle", 32'(ctrl_busy), 0);
    chk("mr_no_wren", 32'(WrEn),      0);
    step();
    step();
    chk("mr_wr_pulses", 32'(wr_cnt), 1);

    // overrun during RD_WAIT with a slow register file
    rf_lat = 2;
    drive(8'hBB); step();
    drive(8'h03);                               // N+1
    step();                                     // N+2, RD_WAIT
    drive(8'h11);                               // N+3
    chk("ov_err",  32'(cmd_err),   1);
    chk("ov_busy", 32'(ctrl_busy), 1);
    step();                                     // N+4
    chk("ov_err_off", 32'(cmd_err),  0);
    chk("ov_notx",    32'(tx_d_vld), 0);
    step();                                     // N+5
    chk("ov_txvld", 32'(tx_d_vld),  1);
    chk("ov_txdat", 32'(tx_p_data), 32'h5C);
    step();
    chk("ov_txvld_off", 32'(tx_d_vld),  0);
    chk("ov_idle",      32'(ctrl_busy), 0);
    step(); step();

    chk("tot_wr",   32'(wr_cnt),   1);
    chk("tot_rd",   32'(rd_cnt),   4);
    chk("tot_err",  32'(err_cnt),  5);
    chk("tot_both", 32'(both_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_cmd_ctrl.md
# rf_cmd_ctrl

Command sequencer that owns the register file's access port. It parses a byte stream from the UART receive path into register-file write/read commands. It drives `WrEn`/`RdEn`/`Address`/`WrData` with single-cycle strobes and returns read data to the UART transmit path over a valid/busy handshake. It sits between UART RX/TX (after their clock-domain synchronisers) and the register file, in the register-file clock domain.

## Interface
- `BUS_WIDTH`, 8: register and frame byte width; it is fixed at 8.
- `ADDR_WIDTH`, 4: register-file address width, which must be ≤ 8.
- `RD_TIMEOUT`, 4: cycles to wait for `RdData_Valid` after `RdEn` before aborting.

One clock; reset is asynchronous and active-low. Ports:

- `CLK` in 1: clock.
- `RST` in 1: asynchronous active-low reset.
- `rx_p_data` in 8: received byte.
- `rx_d_vld` in 1: single-cycle pulse, one per byte.
- `RdData` in BUS_WIDTH: register-file read data.
- `RdData_Valid` in 1: register-file read-data valid.
- `tx_busy` in 1: TX cannot accept a byte.
- `WrEn` out 1: register-file write strobe.
- `RdEn` out 1: register-file read strobe.
- `Address` out ADDR_WIDTH: register-file address.
- `WrData` out BUS_WIDTH: register-file write data.
- `tx_p_data` out 8: byte to transmit.
- `tx_d_vld` out 1: transmit byte valid.
- `ctrl_busy` out 1: high in every state except IDLE.
- `cmd_err` out 1: single-cycle error pulse.

## Operation
- Opcodes:
  - `CMD_RF_WR` = 0xAA, frame is opcode, address, data.
  - `CMD_RF_RD` = 0xBB, frame is opcode, address.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
- IDLE:
  - byte 0xAA → WR_ADDR.
  - byte 0xBB → RD_ADDR.
  - any other byte → pulse `cmd_err`, stay in IDLE.
- WR_ADDR / RD_ADDR, on a byte:
  - If bits [7:ADDR_WIDTH] are nonzero, pulse `cmd_err` and go to IDLE.
  - Otherwise latch `Address` = byte[ADDR_WIDTH-1:0] and go to WR_DATA or RD_EXEC respectively.
- WR_DATA: on a byte, latch `WrData` and go to WR_EXEC.
- WR_EXEC: `WrEn`=1 for exactly this cycle, then IDLE.
- RD_EXEC: `RdEn`=1 for exactly this cycle, then RD_WAIT with the timeout counter cleared.
- RD_WAIT:
  - On `RdData_Valid`, capture `RdData` into `tx_p_data` and go to TX_SEND.
  - If the counter reaches RD_TIMEOUT, pulse `cmd_err` and go to IDLE.
- TX_SEND: hold `tx_d_vld`=1 with `tx_p_data` stable. The transfer completes in the cycle where `tx_d_vld`=1 and `tx_busy`=0; next state is IDLE with `tx_d_vld`=0.
- `WrEn` and `RdEn` are never high in the same cycle. The register file ignores both when both are high.
- A `rx_d_vld` arriving in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND is dropped and pulses `cmd_err`. The current command continues unaffected.
- No inter-byte timeout. A partial frame waits indefinitely for its next byte.

## Timing
- All outputs are registered. Reset values:
  - `WrEn`, `RdEn`, `tx_d_vld`, `ctrl_busy`, `cmd_err` = 0.
  - `Address`, `WrData`, `tx_p_data` = 0.
  - State = IDLE, timeout counter = 0.
- Write: data byte valid at cycle N → `WrEn`=1 at N+1 only. `Address`/`WrData` are stable from N+1 until the next command latches.
- Read: address byte valid at N → `RdEn`=1 at N+1 → `RdData_Valid` expected at N+2 → `tx_d_vld`=1 from N+3.
- Minimum read-to-TX latency is 3 cycles from the address byte, plus any `tx_busy` stall.
- `cmd_err` is high for exactly one cycle per error event.
- Reset asserted mid-command returns all outputs to reset values immediately. Any partial frame or pending TX byte is discarded.
- Back-to-back frames: a new opcode is accepted in the cycle after returning to IDLE. Byte spacing ≥ 1 cycle is guaranteed by UART RX.

## Structure
- Package `rf_ctrl_pkg`: state enum, `CMD_RF_WR`/`CMD_RF_RD` opcode constants.
- Single module; the FSM, timeout counter and output registers live in one file.
- No sub-module is natural at this size.

## Test plan
- Write then readback:
  - Stimulus: AA,03,5C, then BB,03; `tx_busy`=0.
  - Required: one `WrEn` pulse with `Address`=3 and `WrData`=0x5C, then one `RdEn` pulse with `Address`=3.
  - Required: `tx_d_vld` with `tx_p_data`=0x5C three cycles after the 0x03 address byte, and `cmd_err` never asserted.
- TX back-pressure:
  - Stimulus: read frame with `tx_busy`=1 for 10 cycles.
  - Required: `tx_d_vld` and `tx_p_data` held stable; the byte is released and the FSM returns to IDLE one cycle after `tx_busy` falls.
- Illegal input:
  - Stimulus: opcode 0x5A, then frame AA,F2 with ADDR_WIDTH=4.
  - Required: two `cmd_err` pulses, no `WrEn`/`RdEn` pulse, FSM back in IDLE.
- Read timeout:
  - Stimulus: register-file model withholds `RdData_Valid` after BB,01.
  - Required: `cmd_err` pulse RD_TIMEOUT=4 cycles into RD_WAIT, no `tx_d_vld`.
- Reset mid-frame:
  - Stimulus: AA,02, then `RST` low for 2 cycles, then 0x77.
  - Required: no `WrEn`, and 0x77 is treated as an illegal opcode (`cmd_err` pulse).
- Overrun:
  - Stimulus: a byte injected during RD_WAIT.
  - Required: `cmd_err` pulse, and read data still transmitted correctly.
